// File: rtl/cpu_checker_pkg.sv
// Shared constants and types for the cpu_checker front end.
// Trace-line framing characters, bus widths and arbiter states.
package cpu_checker_pkg;

  localparam int CHAR_W = 8;
  localparam int FREQ_W = 16;
  localparam int FMT_W  = 2;
  localparam int ERR_W  = 4;

  localparam logic [CHAR_W-1:0] CH_START = 8'h5E;
  localparam logic [CHAR_W-1:0] CH_END   = 8'h23;
  localparam logic [CHAR_W-1:0] CH_NULL  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DRAIN,
    CAPT
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at index >= ptr, wrapping.
// Purely combinational, one-hot grant plus binary index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = SW'(j);
      end
    end
  end

endmodule

// File: rtl/checker_stream_arbiter.sv
// Shares one cpu_checker between N_SRC trace character streams,
// granting a whole '^'..'#' line at a time and tagging results.
module checker_stream_arbiter
  import cpu_checker_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int MAX_LEN = 64,
  parameter int SW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [CHAR_W*N_SRC-1:0] src_char,
  input  logic [FREQ_W*N_SRC-1:0] src_freq,
  output logic [N_SRC-1:0]        src_ready,
  output logic [CHAR_W-1:0]       chk_char,
  output logic [FREQ_W-1:0]       chk_freq,
  input  logic [FMT_W-1:0]        chk_format_type,
  input  logic [ERR_W-1:0]        chk_error_code,
  output logic                    res_valid,
  output logic [SW-1:0]           res_src,
  output logic [FMT_W-1:0]        res_format,
  output logic [ERR_W-1:0]        res_error,
  output logic                    res_abort
);

  localparam int LW = $clog2(MAX_LEN + 1);

  arb_state_t state, state_nx;

  logic [SW-1:0]     rr_ptr, g, g_nxt, win;
  logic [LW-1:0]     len;
  logic [N_SRC-1:0]  cand, gnt;
  logic              any, abort;
  logic              g_valid;
  logic [CHAR_W-1:0] g_char;
  logic [FREQ_W-1:0] win_freq;

  rr_arbiter #(.N(N_SRC), .SW(SW)) u_rr (
    .req (cand),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  always_comb begin
    cand     = '0;
    g_char   = CH_NULL;
    g_valid  = 1'b0;
    win_freq = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand[i] = src_valid[i] &&
                (src_char[CHAR_W*i +: CHAR_W] == CH_START);
      if (SW'(i) == g) begin
        g_char  = src_char[CHAR_W*i +: CHAR_W];
        g_valid = src_valid[i];
      end
      if (gnt[i]) win_freq = src_freq[FREQ_W*i +: FREQ_W];
    end
  end

  assign g_nxt = (g == SW'(N_SRC - 1)) ? '0 : g + 1'b1;

  // Idle: non-'^' traffic is swallowed, losing '^' is held.
  always_comb begin
    src_ready = '0;
    case (state)
      IDLE: src_ready = src_valid & (~cand | gnt);
      FWD: begin
        for (int i = 0; i < N_SRC; i++)
          src_ready[i] = (SW'(i) == g) && src_valid[i];
      end
      default: src_ready = '0;
    endcase
  end

  // Abort when the MAX_LEN-th character is not the terminator.
  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE: if (any) state_nx = FWD;
      FWD: begin
        if (!g_valid ||
            (g_char != CH_END && len == LW'(MAX_LEN - 1))) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (g_char == CH_END) begin
          state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      g          <= '0;
      len        <= '0;
      chk_char   <= CH_NULL;
      chk_freq   <= '0;
      res_valid  <= 1'b0;
      res_src    <= '0;
      res_format <= '0;
      res_error  <= '0;
      res_abort  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            chk_char <= CH_START;
            chk_freq <= win_freq;
            len      <= LW'(1);
            g        <= win;
          end else begin
            chk_char <= CH_NULL;
          end
        end
        FWD: begin
          if (abort) begin
            chk_char   <= CH_NULL;
            res_valid  <= 1'b1;
            res_abort  <= 1'b1;
            res_src    <= g;
            res_format <= '0;
            res_error  <= '0;
            rr_ptr     <= g_nxt;
          end else begin
            chk_char <= g_char;
            len      <= len + 1'b1;
          end
        end
        DRAIN: chk_char <= CH_NULL;
        CAPT: begin
          res_format <= chk_format_type;
          res_error  <= chk_error_code;
          res_src    <= g;
          res_abort  <= 1'b0;
          res_valid  <= 1'b1;
          rr_ptr     <= g_nxt;
        end
        default: chk_char <= CH_NULL;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_stream_arbiter.sv
// Directed bench for checker_stream_arbiter: instance 0 uses
// MAX_LEN=64, instance 1 uses MAX_LEN=16; both share stimulus.
module tb_checker_stream_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  src_valid;
  logic [15:0] src_char;
  logic [31:0] src_freq;
  logic [1:0]  fmt;
  logic [3:0]  err;

  logic [1:0]  rdy [2];
  logic [7:0]  cc  [2];
  logic [15:0] cf  [2];
  logic        rv  [2];
  logic [0:0]  rs  [2];
  logic [1:0]  rf  [2];
  logic [3:0]  re  [2];
  logic        ra  [2];

  int n_err;
  int n_chk;

  string L1, L2, L3, L16, L20;

  checker_stream_arbiter dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_char(src_char),
    .src_freq(src_freq), .src_ready(rdy[0]),
    .chk_char(cc[0]), .chk_freq(cf[0]),
    .chk_format_type(fmt), .chk_error_code(err),
    .res_valid(rv[0]), .res_src(rs[0]),
    .res_format(rf[0]), .res_error(re[0]),
    .res_abort(ra[0])
  );

  checker_stream_arbiter #(.MAX_LEN(16)) dut16 (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_char(src_char),
    .src_freq(src_freq), .src_ready(rdy[1]),
    .chk_char(cc[1]), .chk_freq(cf[1]),
    .chk_format_type(fmt), .chk_error_code(err),
    .res_valid(rv[1]), .res_src(rs[1]),
    .res_format(rf[1]), .res_error(re[1]),
    .res_abort(ra[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int w);
    chk("rst_char", 32'(cc[w]), 0);
    chk("rst_freq", 32'(cf[w]), 0);
    chk("rst_rv", 32'(rv[w]), 0);
    chk("rst_src", 32'(rs[w]), 0);
    chk("rst_fmt", 32'(rf[w]), 0);
    chk("rst_err", 32'(re[w]), 0);
    chk("rst_abort", 32'(ra[w]), 0);
    chk("rst_ready", 32'(rdy[w]), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    src_valid = '0;
    @(negedge clk);
    check_zero(0);
    check_zero(1);
    reset = 1'b0;
  endtask

  // Caller has already presented line[0] ('^') on source s.
  task automatic stream(input int w, input int s,
                        input string line, input int last);
    for (int k = 1; k < last; k++) begin
      @(negedge clk);
      chk("echo", 32'(cc[w]), 32'(line[k-1]));
      src_char[8*s +: 8] = line[k];
      #1 chk("ready_fwd", 32'(rdy[w][s]), 1);
    end
  endtask

  task automatic expect_result(input int w, input int s,
                               input int f, input int e);
    @(negedge clk);
    chk("echo_end", 32'(cc[w]), 32'h23);
    chk("rv_e0", 32'(rv[w]), 0);
    src_valid[s] = 1'b0;
    @(negedge clk);
    chk("drain_char", 32'(cc[w]), 0);
    chk("rv_e1", 32'(rv[w]), 0);
    @(negedge clk);
    chk("rv_e2", 32'(rv[w]), 1);
    chk("res_src", 32'(rs[w]), 32'(s));
    chk("res_fmt", 32'(rf[w]), 32'(f));
    chk("res_err", 32'(re[w]), 32'(e));
    chk("res_abort", 32'(ra[w]), 0);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    L1  = "^242@000030f4: $31 <= 12321#";
    L2  = "^338@00003130: *00000088 <= ffffb528#";
    L3  = "^242@0000";
    L16 = "^0123456789abcd#";
    L20 = "^0123456789abcdefghi";
    reset     = 1'b1;
    src_valid = '0;
    src_char  = '0;
    src_freq  = {16'd7, 16'd2};
    fmt       = 2'd1;
    err       = 4'd0;
    do_reset();

    // single source, full line
    @(negedge clk);
    src_valid[0] = 1'b1;
    src_char[7:0] = "^";
    #1 chk("ready_t1", 32'(rdy[0]), 2'b01);
    stream(0, 0, L1, L1.len());
    chk("freq_t1", 32'(cf[0]), 2);
    expect_result(0, 0, 1, 0);
    @(negedge clk);
    chk("rv_pulse", 32'(rv[0]), 0);

    // simultaneous '^', then held loser
    do_reset();
    @(negedge clk);
    src_valid = 2'b11;
    src_char  = {"^", "^"};
    #1 chk("ready_tie", 32'(rdy[0]), 2'b01);
    stream(0, 0, L1, L1.len());
    chk("loser_held", 32'(rdy[0][1]), 0);
    expect_result(0, 0, 1, 0);
    #1 chk("ready_next", 32'(rdy[0]), 2'b10);
    fmt = 2'd2;
    stream(0, 1, L2, L2.len());
    chk("freq_t2", 32'(cf[0]), 7);
    expect_result(0, 1, 2, 0);

    // pointer back at 0, then gap abort on source 0
    src_valid = 2'b11;
    src_char  = {"^", "^"};
    #1 chk("ready_wrap", 32'(rdy[0]), 2'b01);
    src_valid[1] = 1'b0;
    stream(0, 0, L3, L3.len());
    @(negedge clk);
    chk("echo_gap", 32'(cc[0]), "0");
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("gap_rv", 32'(rv[0]), 1);
    chk("gap_abort", 32'(ra[0]), 1);
    chk("gap_src", 32'(rs[0]), 0);
    chk("gap_char", 32'(cc[0]), 0);
    chk("gap_fmt", 32'(rf[0]), 0);
    for (int k = 0; k < 4; k++) begin
      src_valid[0] = 1'b1;
      src_char[7:0] = (k % 2 == 0) ? "3" : "f";
      #1 chk("trail_rdy", 32'(rdy[0]), 2'b01);
      @(negedge clk);
      chk("trail_char", 32'(cc[0]), 0);
      chk("trail_rv", 32'(rv[0]), 0);
    end
    src_valid = '0;

    // garbage on source 1 while idle
    for (int k = 0; k < 3; k++) begin
      src_valid[1] = 1'b1;
      src_char[15:8] = (k == 0) ? "a" : (k == 1) ? "b" : " ";
      #1 chk("junk_rdy", 32'(rdy[0]), 2'b10);
      @(negedge clk);
      chk("junk_char", 32'(cc[0]), 0);
      chk("junk_rv", 32'(rv[0]), 0);
    end
    src_valid = '0;

    // MAX_LEN=16: exact-length line completes
    do_reset();
    fmt = 2'd3;
    err = 4'd5;
    @(negedge clk);
    src_valid[0] = 1'b1;
    src_char[7:0] = "^";
    stream(1, 0, L16, L16.len());
    expect_result(1, 0, 3, 5);

    // MAX_LEN=16: 20-char line aborts on its 16th character
    src_valid[0] = 1'b1;
    src_char[7:0] = "^";
    stream(1, 0, L20, 16);
    @(negedge clk);
    chk("ovf_rv", 32'(rv[1]), 1);
    chk("ovf_abort", 32'(ra[1]), 1);
    chk("ovf_src", 32'(rs[1]), 0);
    chk("ovf_char", 32'(cc[1]), 0);
    chk("ovf_fmt", 32'(rf[1]), 0);
    chk("ovf_err", 32'(re[1]), 0);
    for (int k = 16; k < 20; k++) begin
      src_char[7:0] = L20[k];
      #1 chk("ovf_rdy", 32'(rdy[1][0]), 1);
      @(negedge clk);
      chk("ovf_rv_tail", 32'(rv[1]), 0);
      chk("ovf_char_tail", 32'(cc[1]), 0);
    end
    src_valid = '0;
    @(negedge clk);
    @(negedge clk);

    // reset mid-line, then a clean line
    src_freq[15:0] = 16'd3;
    fmt = 2'd1;
    err = 4'd4;
    @(negedge clk);
    src_valid[0] = 1'b1;
    src_char[7:0] = "^";
    stream(0, 0, L1, 8);
    @(negedge clk);
    chk("echo_mid", 32'(cc[0]), "0");
    reset = 1'b1;
    src_valid = '0;
    @(negedge clk);
    check_zero(0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rv", 32'(rv[0]), 0);
    src_valid[0] = 1'b1;
    src_char[7:0] = "^";
    stream(0, 0, L1, L1.len());
    chk("freq_t6", 32'(cf[0]), 3);
    expect_result(0, 0, 1, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
